operand_sequencer: RTL and testbench

//  Upstream feeder for Element_Extraction (4-tap complex fixed-point dot product).

---
 rtl/operand_sequencer_if.sv | 40 ++++
 rtl/operand_sequencer.sv | 130 +++++++++++++
 tb/tb_operand_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/operand_sequencer_if.sv
// operand_sequencer_if: element stream in, 4-tap operand set out.
//   in_valid/in_ready/in_r/in_i : element stream, one complex element per beat
//   a1k_r/a1k_i                 : row op_row of A, k = 1..4
//   bk1_r/bk1_i                 : column op_col of B, k = 1..4
//   op_valid/op_ready           : operand set handshake
//   op_row/op_col/op_last       : index of the current set, last = (3,3)
//   mat_done                    : pulse after the final set is taken
//   master = sequencer side, slave = producer/consumer side
interface operand_sequencer_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_r;
   logic [DATA_WIDTH-1:0] in_i;
   logic [DATA_WIDTH-1:0] a11_r, a12_r, a13_r, a14_r;
   logic [DATA_WIDTH-1:0] a11_i, a12_i, a13_i, a14_i;
   logic [DATA_WIDTH-1:0] b11_r, b21_r, b31_r, b41_r;
   logic [DATA_WIDTH-1:0] b11_i, b21_i, b31_i, b41_i;
   logic                  op_valid;
   logic                  op_ready;
   logic [1:0]            op_row;
   logic [1:0]            op_col;
   logic                  op_last;
   logic                  mat_done;
   modport master (
      input  in_valid, in_r, in_i, op_ready,
      output in_ready,
      output a11_r, a12_r, a13_r, a14_r, a11_i, a12_i, a13_i, a14_i,
      output b11_r, b21_r, b31_r, b41_r, b11_i, b21_i, b31_i, b41_i,
      output op_valid, op_row, op_col, op_last, mat_done
   );
   modport slave (
      output in_valid, in_r, in_i, op_ready,
      input  in_ready,
      input  a11_r, a12_r, a13_r, a14_r, a11_i, a12_i, a13_i, a14_i,
      input  b11_r, b21_r, b31_r, b41_r, b11_i, b21_i, b31_i, b41_i,
      input  op_valid, op_row, op_col, op_last, mat_done
   );
endinterface

// File: rtl/operand_sequencer.sv
// operand_sequencer: buffers two 4x4 complex matrices and issues the 16 row/column operand sets.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : operand_sequencer_if.master (element stream in, operand sets out)
module operand_sequencer #(
   parameter int INTEGER_SIZE = 6,
   parameter int FRACT_SIZE   = 10,
   parameter int DATA_WIDTH   = INTEGER_SIZE + FRACT_SIZE
) (
   input  logic                clk,
   input  logic                rst,
   operand_sequencer_if.master bus
);
   typedef enum logic [1:0] {LOAD_A, LOAD_B, ISSUE} state_t;
   state_t                state_q, state_d;
   logic [3:0]            ld_cnt_q, ld_cnt_d;
   logic [3:0]            is_cnt_q, is_cnt_d;
   logic                  mat_done_q, mat_done_d;
   logic                  in_fire;
   logic                  op_fire;
   logic                  issue;
   logic [1:0]            row, col;
   logic [DATA_WIDTH-1:0] a_r [4][4];
   logic [DATA_WIDTH-1:0] a_i [4][4];
   logic [DATA_WIDTH-1:0] b_r [4][4];
   logic [DATA_WIDTH-1:0] b_i [4][4];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LOAD_A;
         ld_cnt_q   <= '0;
         is_cnt_q   <= '0;
         mat_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ld_cnt_q   <= ld_cnt_d;
         is_cnt_q   <= is_cnt_d;
         mat_done_q <= mat_done_d;
      end
   end

   // in_ready is forced low combinationally while rst is asserted.
   always_comb begin
      state_d      = state_q;
      ld_cnt_d     = ld_cnt_q;
      is_cnt_d     = is_cnt_q;
      mat_done_d   = 1'b0;
      bus.in_ready = 1'b0;
      bus.op_valid = 1'b0;
      case (state_q)
         LOAD_A: begin
            bus.in_ready = ~rst;
            if (bus.in_valid & ~rst) begin
               ld_cnt_d = ld_cnt_q + 4'd1;
               state_d  = ld_cnt_q == 4'd15 ? LOAD_B : LOAD_A;
            end
         end
         LOAD_B: begin
            bus.in_ready = ~rst;
            if (bus.in_valid & ~rst) begin
               ld_cnt_d = ld_cnt_q + 4'd1;
               state_d  = ld_cnt_q == 4'd15 ? ISSUE : LOAD_B;
               is_cnt_d = '0;
            end
         end
         ISSUE: begin
            bus.op_valid = 1'b1;
            if (bus.op_ready) begin
               is_cnt_d   = is_cnt_q + 4'd1;
               mat_done_d = is_cnt_q == 4'd15;
               state_d    = is_cnt_q == 4'd15 ? LOAD_A : ISSUE;
            end
         end
         default: state_d = LOAD_A;
      endcase
   end

   assign in_fire = bus.in_valid & bus.in_ready;
   assign op_fire = bus.op_valid & bus.op_ready;

   // ld_cnt is the row-major element index within the matrix being loaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
               a_r[i][j] <= '0;
               a_i[i][j] <= '0;
               b_r[i][j] <= '0;
               b_i[i][j] <= '0;
            end
         end
      end else if (in_fire && state_q == LOAD_A) begin
         a_r[ld_cnt_q[3:2]][ld_cnt_q[1:0]] <= bus.in_r;
         a_i[ld_cnt_q[3:2]][ld_cnt_q[1:0]] <= bus.in_i;
      end else if (in_fire && state_q == LOAD_B) begin
         b_r[ld_cnt_q[3:2]][ld_cnt_q[1:0]] <= bus.in_r;
         b_i[ld_cnt_q[3:2]][ld_cnt_q[1:0]] <= bus.in_i;
      end
   end

   // Operands are driven only while a set is offered so the consumer sees zeros between matrices.
   always_comb begin
      issue        = state_q == ISSUE;
      row          = is_cnt_q[3:2];
      col          = is_cnt_q[1:0];
      bus.op_row   = row;
      bus.op_col   = col;
      bus.op_last  = issue & (is_cnt_q == 4'd15);
      bus.mat_done = mat_done_q;
      bus.a11_r    = issue ? a_r[row][0] : '0;
      bus.a12_r    = issue ? a_r[row][1] : '0;
      bus.a13_r    = issue ? a_r[row][2] : '0;
      bus.a14_r    = issue ? a_r[row][3] : '0;
      bus.a11_i    = issue ? a_i[row][0] : '0;
      bus.a12_i    = issue ? a_i[row][1] : '0;
      bus.a13_i    = issue ? a_i[row][2] : '0;
      bus.a14_i    = issue ? a_i[row][3] : '0;
      bus.b11_r    = issue ? b_r[0][col] : '0;
      bus.b21_r    = issue ? b_r[1][col] : '0;
      bus.b31_r    = issue ? b_r[2][col] : '0;
      bus.b41_r    = issue ? b_r[3][col] : '0;
      bus.b11_i    = issue ? b_i[0][col] : '0;
      bus.b21_i    = issue ? b_i[1][col] : '0;
      bus.b31_i    = issue ? b_i[2][col] : '0;
      bus.b41_i    = issue ? b_i[3][col] : '0;
   end

   logic unused_fire;
   assign unused_fire = op_fire;
endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: directed checks of load, issue order, backpressure, reset and back-to-back matrices.
module tb_operand_sequencer;
   logic        clk_tb = 1'b0;
   logic        rst = 1'b1;
   int          passed = 0;
   int          total = 0;
   logic [15:0] ma_r [4][4];
   logic [15:0] ma_i [4][4];
   logic [15:0] mb_r [4][4];
   logic [15:0] mb_i [4][4];

   operand_sequencer_if #(.DATA_WIDTH(16)) bus ();
   operand_sequencer dut (.clk(clk_tb), .rst(rst), .bus(bus));

   always #5 clk_tb = ~clk_tb;

   task automatic tick();
      @(posedge clk_tb);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
   endtask

   task automatic fill(input int p);
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            case (p)
               1: begin
                  ma_r[i][j] = 16'(4 * i + j + 1);
                  ma_i[i][j] = 16'h0000;
                  mb_r[i][j] = i == j ? 16'h0400 : 16'h0000;
                  mb_i[i][j] = 16'h0000;
               end
               2: begin
                  ma_r[i][j] = 16'(16'h1000 + 16 * i + j);
                  ma_i[i][j] = 16'(16'hF000 + 16 * i + j);
                  mb_r[i][j] = 16'(16'h2000 + 16 * i + j);
                  mb_i[i][j] = 16'(16'h8000 + 16 * i + j);
               end
               3: begin
                  ma_r[i][j] = 16'(16'h3000 + 4 * i + j);
                  ma_i[i][j] = 16'(16'h0100 * i + j);
                  mb_r[i][j] = 16'(16'h7FFF - (4 * i + j));
                  mb_i[i][j] = 16'(16'h8000 + 4 * i + j);
               end
               default: begin
                  ma_r[i][j] = 16'(16'hFFFF - (4 * i + j));
                  ma_i[i][j] = 16'(16'h0A00 + 4 * i + j);
                  mb_r[i][j] = 16'(16'h0500 + 16 * j + i);
                  mb_i[i][j] = 16'(16'hC000 + 16 * i + j);
               end
            endcase
         end
      end
   endtask

   task automatic load_pair(input bit gaps);
      for (int n = 0; n < 32; n++) begin
         bus.in_valid = 1'b1;
         bus.in_r = n < 16 ? ma_r[n >> 2][n & 3] : mb_r[(n - 16) >> 2][(n - 16) & 3];
         bus.in_i = n < 16 ? ma_i[n >> 2][n & 3] : mb_i[(n - 16) >> 2][(n - 16) & 3];
         tick();
         if (gaps && n < 31) begin
            bus.in_valid = 1'b0;
            bus.in_r = 16'h7FFF;
            bus.in_i = 16'h7FFF;
            tick();
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic check_set(input int s);
      int i, j;
      i = s >> 2;
      j = s & 3;
      chk("op_valid", 32'(bus.op_valid), 32'd1);
      chk("op_row", 32'(bus.op_row), 32'(i));
      chk("op_col", 32'(bus.op_col), 32'(j));
      chk("op_last", 32'(bus.op_last), 32'(s == 15));
      chk("a11_r", 32'(bus.a11_r), 32'(ma_r[i][0]));
      chk("a12_r", 32'(bus.a12_r), 32'(ma_r[i][1]));
      chk("a13_r", 32'(bus.a13_r), 32'(ma_r[i][2]));
      chk("a14_r", 32'(bus.a14_r), 32'(ma_r[i][3]));
      chk("a11_i", 32'(bus.a11_i), 32'(ma_i[i][0]));
      chk("a12_i", 32'(bus.a12_i), 32'(ma_i[i][1]));
      chk("a13_i", 32'(bus.a13_i), 32'(ma_i[i][2]));
      chk("a14_i", 32'(bus.a14_i), 32'(ma_i[i][3]));
      chk("b11_r", 32'(bus.b11_r), 32'(mb_r[0][j]));
      chk("b21_r", 32'(bus.b21_r), 32'(mb_r[1][j]));
      chk("b31_r", 32'(bus.b31_r), 32'(mb_r[2][j]));
      chk("b41_r", 32'(bus.b41_r), 32'(mb_r[3][j]));
      chk("b11_i", 32'(bus.b11_i), 32'(mb_i[0][j]));
      chk("b21_i", 32'(bus.b21_i), 32'(mb_i[1][j]));
      chk("b31_i", 32'(bus.b31_i), 32'(mb_i[2][j]));
      chk("b41_i", 32'(bus.b41_i), 32'(mb_i[3][j]));
   endtask

   task automatic walk(input bit stall, input bit junk, input int stop);
      for (int s = 0; s < stop; s++) begin
         check_set(s);
         chk("in_ready_issue", 32'(bus.in_ready), 32'd0);
         chk("mat_done_low", 32'(bus.mat_done), 32'd0);
         if (stall && s == 6) begin
            bus.op_ready = 1'b0;
            repeat (3) begin
               tick();
               check_set(6);
            end
            bus.op_ready = 1'b1;
         end
         bus.in_valid = junk && s < 4;
         bus.in_r = 16'h7FFF;
         bus.in_i = 16'h7FFF;
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_r = '0;
      bus.in_i = '0;
      bus.op_ready = 1'b1;
      tick();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("rst_in_ready_after", 32'(bus.in_ready), 32'd1);
      chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
      chk("rst_mat_done", 32'(bus.mat_done), 32'd0);
      chk("rst_a11_r", 32'(bus.a11_r), 32'd0);
      chk("rst_b11_r", 32'(bus.b11_r), 32'd0);
      chk("rst_op_last", 32'(bus.op_last), 32'd0);

      fill(1);
      load_pair(1'b1);
      walk(1'b1, 1'b1, 16);
      chk("done1_mat_done", 32'(bus.mat_done), 32'd1);
      chk("done1_in_ready", 32'(bus.in_ready), 32'd1);
      chk("done1_op_valid", 32'(bus.op_valid), 32'd0);
      tick();
      chk("done1_pulse_end", 32'(bus.mat_done), 32'd0);

      fill(2);
      load_pair(1'b0);
      walk(1'b0, 1'b0, 9);
      check_set(9);
      rst = 1'b1;
      #1;
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("midrst_op_valid", 32'(bus.op_valid), 32'd0);
      chk("midrst_in_ready_after", 32'(bus.in_ready), 32'd1);
      chk("midrst_a11_r", 32'(bus.a11_r), 32'd0);
      chk("midrst_b41_i", 32'(bus.b41_i), 32'd0);
      chk("midrst_op_row", 32'(bus.op_row), 32'd0);
      chk("midrst_op_col", 32'(bus.op_col), 32'd0);
      chk("midrst_mat_done", 32'(bus.mat_done), 32'd0);

      fill(3);
      load_pair(1'b0);
      walk(1'b0, 1'b0, 16);
      chk("done3_mat_done", 32'(bus.mat_done), 32'd1);
      chk("done3_in_ready", 32'(bus.in_ready), 32'd1);

      fill(4);
      load_pair(1'b0);
      walk(1'b0, 1'b0, 16);
      chk("done4_mat_done", 32'(bus.mat_done), 32'd1);
      chk("done4_op_valid", 32'(bus.op_valid), 32'd0);
      tick();
      chk("done4_pulse_end", 32'(bus.mat_done), 32'd0);
      chk("done4_in_ready", 32'(bus.in_ready), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
